// File: rtl/mux_nt1_reg.sv
// mux_nt1_reg: registered N:1 selector for the program-counter source path.
// One of NSRC packed n-bit sources is captured into D_OUT on a rising edge
// when a capture is requested, not stalled, and the select is in range.
// Alongside the data it records the select used, a valid flag, a one-cycle
// source-change pulse and a sticky illegal-select error.
//
// Control semantics: LD is a capture request sampled on every rising edge.
// STALL overrides LD and freezes the data, select and valid registers.
// There is no backpressure: a request that is stalled or carries an
// out-of-range SEL is dropped, not queued. Out-of-range SEL only raises ERR.
// All outputs come straight from flops; nothing combinational reaches them.
module mux_nt1_reg #(
    parameter int             n       = 32,
    parameter int             NSRC    = 4,
    parameter logic [n-1:0]   RST_VAL = '0,
    localparam int            SW      = $clog2(NSRC)
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [SW-1:0]       SEL,
    input  logic [NSRC*n-1:0]   D_IN,
    input  logic                LD,
    input  logic                STALL,
    input  logic                ERR_CLR,
    output logic [n-1:0]        D_OUT,
    output logic                VALID,
    output logic [SW-1:0]       SEL_Q,
    output logic                CHG,
    output logic                ERR
);

    // Source count held one bit wider than SEL so that the range check
    // compares against the full value of NSRC (e.g. NSRC=4 with SW=2).
    localparam logic [SW:0] nsrc_limit = NSRC[SW:0];

    logic [n-1:0]  sel_data;
    logic          sel_legal;
    logic          cap;
    logic          bad_req;

    logic [n-1:0]  d_out_q;
    logic          valid_q;
    logic [SW-1:0] sel_q;
    logic          chg_q;
    logic          err_q;

    // Range check of the select, widened to avoid truncating NSRC.
    assign sel_legal = ({1'b0, SEL} < nsrc_limit);

    // Capture happens only for an unstalled request with a legal select;
    // an unstalled request with an illegal select sets the sticky error.
    assign cap     = LD & ~STALL & sel_legal;
    assign bad_req = LD & ~STALL & ~sel_legal;

    // Combinational source select; defaults to zero for unmatched indices.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (SEL == SW'(k)) begin
                sel_data = D_IN[k*n +: n];
            end
        end
    end

    // All state: captured data, select, valid, change pulse and sticky error.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            d_out_q <= RST_VAL;
            valid_q <= 1'b0;
            sel_q   <= '0;
            chg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // The change pulse is rebuilt every edge, so it lasts one cycle.
            chg_q <= cap & valid_q & (SEL != sel_q);
            if (cap) begin
                d_out_q <= sel_data;
                sel_q   <= SEL;
                valid_q <= 1'b1;
            end
            // A new illegal request beats a simultaneous clear.
            if (bad_req) begin
                err_q <= 1'b1;
            end else if (ERR_CLR) begin
                err_q <= 1'b0;
            end
        end
    end

    assign D_OUT = d_out_q;
    assign VALID = valid_q;
    assign SEL_Q = sel_q;
    assign CHG   = chg_q;
    assign ERR   = err_q;

endmodule

// File: tb/tb_mux_nt1_reg.sv
// tb_mux_nt1_reg: directed scenarios on a 4-source and a 5-source instance,
// then a randomized run on a 16-source 8-bit instance against a model.
module tb_mux_nt1_reg;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A: NSRC=4, n=32 ----------------
    logic [1:0]    a_sel;
    logic [127:0]  a_d_in;
    logic          a_ld, a_stall, a_err_clr;
    logic [31:0]   a_d_out;
    logic          a_valid, a_chg, a_err;
    logic [1:0]    a_sel_q;

    mux_nt1_reg #(.n(32), .NSRC(4)) u_a (
        .CLK(clk), .RST_N(rst_n), .SEL(a_sel), .D_IN(a_d_in), .LD(a_ld),
        .STALL(a_stall), .ERR_CLR(a_err_clr), .D_OUT(a_d_out), .VALID(a_valid),
        .SEL_Q(a_sel_q), .CHG(a_chg), .ERR(a_err)
    );

    // ---------------- instance B: NSRC=5, n=32 ----------------
    logic [2:0]    b_sel;
    logic [159:0]  b_d_in;
    logic          b_ld, b_stall, b_err_clr;
    logic [31:0]   b_d_out;
    logic          b_valid, b_chg, b_err;
    logic [2:0]    b_sel_q;

    mux_nt1_reg #(.n(32), .NSRC(5)) u_b (
        .CLK(clk), .RST_N(rst_n), .SEL(b_sel), .D_IN(b_d_in), .LD(b_ld),
        .STALL(b_stall), .ERR_CLR(b_err_clr), .D_OUT(b_d_out), .VALID(b_valid),
        .SEL_Q(b_sel_q), .CHG(b_chg), .ERR(b_err)
    );

    // ---------------- instance C: NSRC=16, n=8 ----------------
    logic [3:0]    c_sel;
    logic [127:0]  c_d_in;
    logic          c_ld, c_stall, c_err_clr;
    logic [7:0]    c_d_out;
    logic          c_valid, c_chg, c_err;
    logic [3:0]    c_sel_q;

    mux_nt1_reg #(.n(8), .NSRC(16)) u_c (
        .CLK(clk), .RST_N(rst_n), .SEL(c_sel), .D_IN(c_d_in), .LD(c_ld),
        .STALL(c_stall), .ERR_CLR(c_err_clr), .D_OUT(c_d_out), .VALID(c_valid),
        .SEL_Q(c_sel_q), .CHG(c_chg), .ERR(c_err)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [1:0] sel, input logic ld, input logic stall);
        a_sel = sel; a_ld = ld; a_stall = stall;
    endtask

    task automatic drive_b(input logic [2:0] sel, input logic ld, input logic clr);
        b_sel = sel; b_ld = ld; b_err_clr = clr;
    endtask

    // ---------------- scoreboard state for the random run ----------------
    logic [7:0] exp_q[$];
    logic [7:0] src[16];
    logic [7:0] m_dout;
    logic [3:0] m_selq;
    logic       m_valid;
    logic       m_chg;
    int         m_chg_count;
    int         dut_chg_count;

    initial begin
        rst_n = 1'b1;
        a_sel = '0; a_ld = 0; a_stall = 0; a_err_clr = 0;
        b_sel = '0; b_ld = 0; b_stall = 0; b_err_clr = 0;
        c_sel = '0; c_ld = 0; c_stall = 0; c_err_clr = 0;
        a_d_in = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
        b_d_in = {32'h55550004, 32'h44440003, 32'h33330002, 32'h22220001, 32'h11110000};
        c_d_in = '0;

        // Reset asserted before any clock edge: outputs follow immediately.
        #1 rst_n = 1'b0;
        #1;
        check("rst_a_dout", a_d_out, 0);
        check("rst_a_valid", a_valid, 0);
        check("rst_a_selq", a_sel_q, 0);
        check("rst_a_chg", a_chg, 0);
        check("rst_a_err", a_err, 0);
        check("rst_c_valid", c_valid, 0);

        // Release mid-cycle; first capture on the next edge with LD.
        #10 rst_n = 1'b1;
        drive_a(2'd2, 1, 0);
        step();
        check("s1_dout", a_d_out, 32'hCCCC0002);
        check("s1_selq", a_sel_q, 2);
        check("s1_valid", a_valid, 1);
        check("s1_chg", a_chg, 0);

        // Same select again: no change; then a new select: one-cycle pulse.
        drive_a(2'd2, 1, 0);
        step();
        check("s2_chg_same", a_chg, 0);
        drive_a(2'd3, 1, 0);
        step();
        check("s2_chg_new", a_chg, 1);
        check("s2_dout", a_d_out, 32'hDDDD0003);
        drive_a(2'd3, 0, 0);
        step();
        check("s2_chg_drop", a_chg, 0);
        check("s2_dout_hold", a_d_out, 32'hDDDD0003);

        // Stall overrides load for three edges, then capture goes through.
        for (int i = 0; i < 3; i++) begin
            drive_a(2'd0, 1, 1);
            step();
            check("s3_stall_dout", a_d_out, 32'hDDDD0003);
            check("s3_stall_chg", a_chg, 0);
            check("s3_stall_selq", a_sel_q, 3);
        end
        drive_a(2'd0, 1, 0);
        step();
        check("s3_dout", a_d_out, 32'hAAAA0000);
        check("s3_chg", a_chg, 1);
        drive_a(2'd0, 0, 0);

        // Illegal selects on the 5-source instance.
        drive_b(3'd4, 1, 0);
        step();
        check("s4_dout_top", b_d_out, 32'h55550004);
        check("s4_chg_first", b_chg, 0);
        drive_b(3'd6, 1, 0);
        step();
        check("s4_err_set", b_err, 1);
        check("s4_dout_hold", b_d_out, 32'h55550004);
        check("s4_selq_hold", b_sel_q, 4);
        check("s4_chg_ill", b_chg, 0);
        drive_b(3'd6, 0, 0);
        step();
        check("s4_err_held", b_err, 1);
        drive_b(3'd6, 1, 1);
        step();
        check("s4_err_setwins", b_err, 1);
        drive_b(3'd1, 1, 1);
        step();
        check("s4_err_clr", b_err, 0);
        check("s4_dout_d1", b_d_out, 32'h22220001);
        check("s4_chg_d1", b_chg, 1);
        b_stall = 1;
        drive_b(3'd7, 1, 0);
        step();
        check("s4_err_stalled", b_err, 0);
        b_stall = 0;
        drive_b(3'd5, 1, 0);
        step();
        check("s4_err_sel5", b_err, 1);
        check("s4_dout_sel5", b_d_out, 32'h22220001);
        check("s4_valid", b_valid, 1);
        drive_b(3'd0, 0, 0);

        // Asynchronous reset pulse between edges.
        #2 rst_n = 1'b0;
        #1;
        check("s5_a_dout", a_d_out, 0);
        check("s5_a_valid", a_valid, 0);
        check("s5_a_selq", a_sel_q, 0);
        check("s5_b_err", b_err, 0);
        check("s5_b_valid", b_valid, 0);
        #1 rst_n = 1'b1;
        drive_a(2'd1, 1, 0);
        step();
        check("s5_dout", a_d_out, 32'hBBBB0001);
        check("s5_chg_first", a_chg, 0);
        check("s5_valid", a_valid, 1);
        drive_a(2'd0, 0, 0);

        // Randomized run on the 16-source instance.
        m_dout = 8'h00; m_selq = 4'd0; m_valid = 0; m_chg = 0;
        m_chg_count = 0; dut_chg_count = 0;
        for (int i = 0; i < 10000; i++) begin
            for (int k = 0; k < 16; k++) begin
                src[k] = 8'($urandom_range(0, 255));
                c_d_in[k*8 +: 8] = src[k];
            end
            c_sel     = 4'($urandom_range(0, 15));
            c_ld      = ($urandom_range(0, 99) < 60);
            c_stall   = ($urandom_range(0, 99) < 25);
            c_err_clr = 1'($urandom_range(0, 1));
            // Model: a granted load takes the chosen source; a change is
            // counted when a prior capture exists with a different index.
            m_chg = 0;
            if (c_ld && !c_stall) begin
                m_chg   = m_valid && (c_sel != m_selq);
                m_dout  = src[c_sel];
                m_selq  = c_sel;
                m_valid = 1;
            end
            if (m_chg) m_chg_count++;
            exp_q.push_back(m_dout);
            step();
            check("rnd_dout", c_d_out, exp_q.pop_front());
            check("rnd_chg", c_chg, m_chg);
            check("rnd_valid", c_valid, m_valid);
            check("rnd_selq", c_sel_q, m_selq);
            if (c_chg) dut_chg_count++;
        end
        check("rnd_chg_count", dut_chg_count, m_chg_count);
        check("rnd_err", c_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
